mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux output among four requesters.
- Each requester drives its own data slice and a request line.
- The block registers the mux select, issues one-hot grants, and bounds each grant tenure to MAX_HOLD cycles for fairness.
- Sits in front of the mux datapath; the 4:1 mux is instantiated inside, so downstream logic sees only o, s and gnt.

Parameters:
- WIDTH, 1, bit width of each requester data slice and of o.
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant (legal range 1..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i.
- a  input  4*WIDTH  packed data; slice i = a[i*WIDTH +: WIDTH].
- gnt  output  4  one-hot grant, registered; all zero when idle.
- s  output  2  registered mux select = index of current/last grantee.
- o  output  WIDTH  selected data, a[s] when busy, else all zero (combinational from registered s/busy).
- busy  output  1  high while a grant is active.

Behaviour:
Interface
- One clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n=0: gnt=0, s=2'b00, o=0, busy=0, hold_cnt=0, state=IDLE, last=3 (so the first search starts at requester 0).

State machine
- Two states, IDLE and GRANT.
- IDLE, req==0: stay in IDLE; outputs unchanged (gnt=0, busy=0).
- IDLE, req!=0: at the next edge, pick the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - s = winner, gnt = one-hot(winner), busy=1, hold_cnt=0, last=winner, go to GRANT.
  - Latency: req sampled at edge N gives gnt visible after edge N+1... precisely, gnt is set at the first rising edge where req is seen (one-cycle registered latency).
- GRANT, continue: when req[s]=1 and hold_cnt < MAX_HOLD-1, increment hold_cnt and keep the grant.
- GRANT, end of tenure: when req[s]=0 or hold_cnt == MAX_HOLD-1:
  - Others requesting: rescan starting at s+1, wrapping (mod 4). The current requester is eligible only last in the scan. Switch gnt/s to the winner in the same edge (no idle bubble) and reset hold_cnt to 0.
  - No requests at all: go to IDLE. gnt=0, busy=0, s holds its last value.
  - Only the current requester still requesting at limit: re-grant it, with hold_cnt reset to 0.

Timing and conditions
- o = a[s] while busy, else 0. o tracks changes on a combinationally within a tenure.
- gnt is always one-hot or zero; never multi-hot.
- Requests dropped mid-tenure end the tenure at the next edge.
- A new request arriving in the same cycle that another drops is handled by the rescan.
- Reset asserted mid-tenure clears everything immediately (asynchronous). After release, arbitration restarts from requester 0.
- Fairness: with all 4 requesting continuously, grant order is 0,1,2,3,0,… with exactly MAX_HOLD cycles each.
- hold_cnt width is 4 bits; MAX_HOLD=1 gives per-cycle rotation.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1), REQ_N=4 constant, SEL_W=2 constant.
- One sub-module: rr_pick4, combinational. Inputs are req[3:0] and start[1:0]; outputs are any and idx[1:0]. It is used for both the IDLE and GRANT rescans.
- The 4:1 data mux stays inline.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, s=0, busy=0, o=0. Release -> after the first edge, gnt=4'b0001, s=0.
- Single requester: req=4'b0100 held 10 cycles, a=4'b1010 (WIDTH=1) -> gnt=4'b0100, s=2, o=0 (a[2]=0). Re-grant to itself every 4 cycles; gnt never drops.
- Full rotation: req=4'b1111, MAX_HOLD=4, a=4'b1010 -> s sequence 0×4, 1×4, 2×4, 3×4, repeating. o = 0,1,0,1 per tenure.
- Early release: grant on 1, drop req[1] after 2 cycles while req=4'b1001 -> next edge s=3, gnt=4'b1000, with no idle cycle.
- Idle return: req goes 4'b0010 -> 4'b0000 -> gnt=0, busy=0, s stays 1, o=0. A later req=4'b0011 -> grant goes to 0 first, since the scan starts at last+1=2 and wraps to 0.
- Async reset mid-tenure: assert rst_n=0 between edges while gnt=4'b0100 -> gnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned REQ_N  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [REQ_N-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return REQ_N'(1) << sel;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating priority picker: first set request at or after start, wrapping mod 4.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any  = 1'b0;
    idx  = start;
    cand = start;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      cand = SEL_W'(start + SEL_W'(i));
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded tenure driving an inline 4:1 data mux.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REQ_N-1:0]       req,
  input  logic [REQ_N*WIDTH-1:0] a,
  output logic [REQ_N-1:0]       gnt,
  output logic [SEL_W-1:0]       s,
  output logic [WIDTH-1:0]       o,
  output logic                   busy
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  s_d;
  logic [REQ_N-1:0]  gnt_d;
  logic              busy_d;

  logic [SEL_W-1:0]  pick_start;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;

  // In GRANT last equals s, so one picker serves both the idle search and the rescan.
  assign pick_start = SEL_W'(last_q + SEL_W'(1));

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SEL_W'(REQ_N - 1);
      hold_q  <= '0;
      s       <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      s       <= s_d;
      gnt     <= gnt_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    s_d     = s;
    gnt_d   = gnt;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          last_d  = pick_idx;
          hold_d  = '0;
          s_d     = pick_idx;
          gnt_d   = sel_onehot(pick_idx);
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (req[s] && (hold_q < HOLD_LAST)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else if (pick_any) begin
          // Current holder is scanned last, so it only wins when alone.
          last_d = pick_idx;
          hold_d = '0;
          s_d    = pick_idx;
          gnt_d  = sel_onehot(pick_idx);
        end else begin
          state_d = IDLE;
          hold_d  = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output mux follows a combinationally within a tenure; zero when idle.
  always_comb begin
    o = '0;
    if (busy) begin
      o = a[32'(s) * WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a tenure model.
module tb_mux4_rr_arbiter;

  localparam int unsigned WIDTH    = 1;
  localparam int unsigned MAX_HOLD = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [3:0]             req;
  logic [4*WIDTH-1:0]     a;
  logic [3:0]             gnt;
  logic [1:0]             s;
  logic [WIDTH-1:0]       o;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner, last winner, cycles spent in current tenure (1-based).
  bit m_busy;
  int m_sel;
  int m_last;
  int m_run;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a     (a),
    .gnt   (gnt),
    .s     (s),
    .o     (o),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_after(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_last = 3;
    m_run  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    if (!m_busy) begin
      w = next_after(m_last, r);
      if (w >= 0) begin
        m_busy = 1'b1; m_sel = w; m_last = w; m_run = 1;
      end
    end else if (r[m_sel] && m_run < int'(MAX_HOLD)) begin
      m_run++;
    end else begin
      w = next_after(m_sel, r);
      if (w >= 0) begin
        m_sel = w; m_last = w; m_run = 1;
      end else begin
        m_busy = 1'b0; m_run = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0]       e_gnt;
    logic [WIDTH-1:0] e_o;
    e_gnt = m_busy ? 4'(1 << m_sel) : 4'b0000;
    e_o   = m_busy ? a[m_sel*WIDTH +: WIDTH] : '0;
    check({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
    check({tag, ".s"},    32'(s),    32'(m_sel));
    check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check({tag, ".o"},    32'(o),    32'(e_o));
    check({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'(1));
  endtask

  // Drive inputs just after an edge, advance one edge, then compare.
  task automatic cycle(input logic [3:0] r, input logic [4*WIDTH-1:0] d, input string tag);
    req = r;
    a   = d;
    @(posedge clk);
    model_step(r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.gnt", 32'(gnt), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b1111;
    a     = 4'b1010;
    model_reset();
    #12;
    check("reset.gnt",  32'(gnt),  32'(0));
    check("reset.s",    32'(s),    32'(0));
    check("reset.busy", 32'(busy), 32'(0));
    check("reset.o",    32'(o),    32'(0));
    rst_n = 1'b1;

    // Full rotation with all requesting: 0x4,1x4,2x4,3x4,0x4
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111, 4'b1010, "rot");
      check("rot.s_seq", 32'(s), 32'((i / 4) % 4));
      check("rot.o_seq", 32'(o), 32'(((i / 4) % 4) & 1));
    end

    // Single requester keeps the grant through repeated re-grants
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0100, 4'b1010, "single");
      check("single.gnt", 32'(gnt), 32'(4'b0100));
      check("single.o", 32'(o), 32'(0));
    end

    // Early release hands over with no idle bubble
    do_reset();
    cycle(4'b0010, 4'b1010, "early");
    cycle(4'b1011, 4'b1010, "early");
    cycle(4'b1001, 4'b1010, "early");
    check("early.s", 32'(s), 32'(3));
    check("early.gnt", 32'(gnt), 32'(4'b1000));

    // Idle return keeps s, then the scan wraps from last+1
    do_reset();
    cycle(4'b0010, 4'b1010, "idle");
    cycle(4'b0000, 4'b1010, "idle");
    check("idle.gnt", 32'(gnt), 32'(0));
    check("idle.s", 32'(s), 32'(1));
    check("idle.o", 32'(o), 32'(0));
    cycle(4'b0011, 4'b1010, "idle");
    check("idle.wrap_s", 32'(s), 32'(0));
    check("idle.wrap_gnt", 32'(gnt), 32'(4'b0001));

    // Asynchronous reset mid-tenure
    do_reset();
    cycle(4'b0100, 4'b1010, "async");
    check("async.pre_gnt", 32'(gnt), 32'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    check("async.gnt", 32'(gnt), 32'(0));
    check("async.busy", 32'(busy), 32'(0));
    check("async.s", 32'(s), 32'(0));
    model_reset();
    rst_n = 1'b1;
    cycle(4'b1100, 4'b1010, "async.restart");

    // Randomized traffic with sticky requests and occasional async reset
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      cycle(r, (4*WIDTH)'($urandom), "rand");
      if ($urandom_range(0, 199) == 0) begin
        #1;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
